// File: rtl/sram_uart_tx_interface_pkg.sv
// Shared types for the board's SRAM <-> UART data path.
package sram_uart_tx_interface_pkg;

  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    S_TOP_IDLE,
    S_UART_RX,
    S_UART_TX
  } top_state_type;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_REQ,
    S_TX_WAIT,
    S_TX_LATCH,
    S_TX_HI,
    S_TX_LO,
    S_TX_DONE
  } tx_state_type;

endpackage

// File: rtl/sram_uart_tx_interface_uart_tx_byte.sv
// 8N1 byte serializer: one tx_load starts a 10-bit frame, LSB first.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       UART_TX_O
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          line_q, line_d;
  logic          bit_end;

  assign bit_end = busy_q && (baud_q == BAUD_LAST);
  // Pulses at the end of the last data bit, so the caller can fetch the
  // next byte while the stop bit is still on the line.
  assign tx_done   = bit_end && (bit_q == 4'd8);
  assign tx_busy   = busy_q;
  assign UART_TX_O = line_q;

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    line_d  = line_q;
    if (tx_load && !busy_q) begin
      shift_d = {1'b1, tx_data, 1'b0};
      line_d  = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          line_d = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[9:1]};
          line_d  = shift_q[1];
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/sram_uart_tx_interface.sv
// Dumps Word_count SRAM words from Base_address over the UART, high byte first.
module sram_uart_tx_interface
  import sram_uart_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT      = UART_CLKS_PER_BIT,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int WW = (SRAM_READ_LATENCY > 2) ? $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [WW-1:0] WAIT_LAST =
    WW'((SRAM_READ_LATENCY > 1) ? SRAM_READ_LATENCY - 2 : 0);

  tx_state_type  state_q, state_d;
  logic [17:0]   addr_q, addr_d;
  logic [17:0]   rem_q, rem_d;
  logic [17:0]   rd_addr_q, rd_addr_d;
  logic [15:0]   word_q, word_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          sent_q, sent_d;

  logic          tx_load, tx_busy, tx_done;
  logic [7:0]    tx_data;

  assign SRAM_we_n = 1'b1;
  assign Busy      = (state_q != S_TX_IDLE) && !Done;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    rd_addr_d    = rd_addr_q;
    word_d       = word_q;
    wait_d       = wait_q;
    sent_d       = sent_q;
    tx_load      = 1'b0;
    tx_data      = word_q[15:8];
    Done         = 1'b0;
    SRAM_address = rd_addr_q;
    case (state_q)
      S_TX_IDLE: begin
        if (Start) begin
          addr_d  = Base_address;
          rem_d   = Word_count;
          state_d = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        if (rem_q == '0) begin
          state_d = S_TX_DONE;
        end else begin
          // Address goes out this cycle and is then held by rd_addr_q.
          SRAM_address = addr_q;
          rd_addr_d    = addr_q;
          wait_d       = '0;
          state_d      = (SRAM_READ_LATENCY > 1) ? S_TX_WAIT : S_TX_LATCH;
        end
      end
      S_TX_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_TX_LATCH;
        else                     wait_d  = wait_q + 1'b1;
      end
      S_TX_LATCH: begin
        word_d  = SRAM_read_data;
        state_d = S_TX_HI;
      end
      S_TX_HI, S_TX_LO: begin
        tx_data = (state_q == S_TX_HI) ? word_q[15:8] : word_q[7:0];
        if (!sent_q && !tx_busy) begin
          tx_load = 1'b1;
          sent_d  = 1'b1;
        end
        if (sent_q && tx_done) begin
          sent_d = 1'b0;
          if (state_q == S_TX_HI) begin
            state_d = S_TX_LO;
          end else begin
            rem_d   = rem_q - 18'd1;
            addr_d  = addr_q + 18'd1;
            state_d = (rem_q == 18'd1) ? S_TX_DONE : S_TX_REQ;
          end
        end
      end
      S_TX_DONE: begin
        // Hold until the final stop bit has left the line.
        if (!tx_busy) begin
          Done    = 1'b1;
          state_d = S_TX_IDLE;
        end
      end
      default: state_d = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_TX_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_addr_q <= '0;
      word_q    <= '0;
      wait_q    <= '0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rd_addr_q <= rd_addr_d;
      word_q    <= word_d;
      wait_q    <= wait_d;
      sent_q    <= sent_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .UART_TX_O  (UART_TX_O)
  );

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Scoreboard bench: expected bytes are queued at Start, a line monitor decodes frames.
module tb_sram_uart_tx_interface;

  localparam int CPB = 4;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn = 1'b0;
  logic        Start = 1'b0;
  logic [17:0] Base_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n, UART_TX_O, Busy, Done;

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  sram_uart_tx_interface #(
    .CLKS_PER_BIT      (CPB),
    .SRAM_READ_LATENCY (2)
  ) dut (
    .CLOCK_50_I     (CLOCK_50_I),
    .resetn         (resetn),
    .Start          (Start),
    .Base_address   (Base_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_we_n      (SRAM_we_n),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  // SRAM model, 2-cycle read latency
  logic [15:0] mem [int];
  logic [17:0] a1 = '0;
  always @(posedge CLOCK_50_I) begin
    a1             <= SRAM_address;
    SRAM_read_data <= mem.exists(int'(a1)) ? mem[int'(a1)] : 16'hDEAD;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] expw(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] w;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) w[i] = f[i / CPB];
    return w;
  endfunction

  logic [7:0] exp_q[$];

  // Line / Done monitor
  int         cyc = 0, rx_cnt = 0, last_end = -1, frames = 0, done_cnt = 0, we_bad = 0;
  bit         rx_act = 0;
  logic       line_prev = 1'b1;
  logic [39:0] rx_cap = '0;
  logic [7:0] eb;

  always @(negedge CLOCK_50_I) begin
    cyc++;
    if (SRAM_we_n !== 1'b1) we_bad++;
    if (!resetn) begin
      rx_act    = 0;
      line_prev = 1'b1;
    end else begin
      if (Done === 1'b1) begin
        done_cnt++;
        chk("busy_low_at_done", Busy, 0);
      end
      if (rx_act) begin
        rx_cap[rx_cnt] = UART_TX_O;
        rx_cnt++;
        if (rx_cnt == 10 * CPB) begin
          rx_act   = 0;
          frames++;
          last_end = cyc;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got waveform %0h, no byte expected", rx_cap);
          end else begin
            eb = exp_q.pop_front();
            n_cmp--;
            chk("frame", rx_cap, expw(eb));
          end
        end
      end else if (line_prev === 1'b1 && UART_TX_O === 1'b0) begin
        rx_act    = 1;
        rx_cap    = '0;
        rx_cnt    = 1;
        if (last_end >= 0) begin
          n_cmp++;
          if (cyc - last_end - 1 > 1) begin
            n_fail++;
            $display("FAIL gap: got %0d idle cycles, required at most 1", cyc - last_end - 1);
          end
        end
      end
      line_prev = UART_TX_O;
    end
  end

  task automatic start(input logic [17:0] b, input logic [17:0] n);
    @(posedge CLOCK_50_I); #1;
    if (!Busy) last_end = -1;
    Base_address = b;
    Word_count   = n;
    Start        = 1'b1;
    @(posedge CLOCK_50_I); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int k = 0;
    while (done_cnt == prev && k < budget) begin
      @(negedge CLOCK_50_I);
      k++;
    end
    chk("done_seen", done_cnt - prev, 1);
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int d, f0, k;
    logic [17:0] pre;
    bit moved;

    // Reset state
    repeat (3) @(negedge CLOCK_50_I);
    chk("rst_tx", UART_TX_O, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_addr", SRAM_address, 0);
    chk("rst_we_n", SRAM_we_n, 1);
    @(posedge CLOCK_50_I); #1 resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);

    // 1: single word A55A
    mem[0] = 16'hA55A;
    push_word(16'hA55A);
    d = done_cnt;
    start(18'h0, 18'd1);
    wait_done(d, 600);
    chk("t1_queue_empty", exp_q.size(), 0);
    repeat (20) @(negedge CLOCK_50_I);
    chk("t1_single_done", done_cnt - d, 1);

    // 2: address wrap 3FFFE -> 3FFFF -> 00000
    mem[18'h3FFFE] = 16'h1111;
    mem[18'h3FFFF] = 16'h2222;
    mem[0]         = 16'h3333;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    d = done_cnt;
    start(18'h3FFFE, 18'd3);
    wait_done(d, 2000);
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_last_addr", SRAM_address, 18'h00000);

    // 3: Word_count = 0
    pre   = SRAM_address;
    moved = 0;
    f0    = frames;
    mem[18'h155] = 16'h0F0F;
    start(18'h155, 18'd0);
    @(negedge CLOCK_50_I);
    chk("t3_busy_c1", Busy, 1);
    chk("t3_done_c1", Done, 0);
    if (SRAM_address !== pre) moved = 1;
    @(negedge CLOCK_50_I);
    chk("t3_done_c2", Done, 1);
    chk("t3_busy_c2", Busy, 0);
    repeat (30) begin
      @(negedge CLOCK_50_I);
      if (SRAM_address !== pre || UART_TX_O !== 1'b1) moved = 1;
    end
    chk("t3_no_activity", moved, 0);
    chk("t3_no_frames", frames - f0, 0);

    // 4: Start during a dump is ignored
    mem[18'h10] = 16'hBEEF;
    mem[18'h11] = 16'hCAFE;
    mem[100]    = 16'h7777;
    push_word(16'hBEEF);
    push_word(16'hCAFE);
    d = done_cnt;
    start(18'h10, 18'd2);
    repeat (30) @(negedge CLOCK_50_I);
    start(18'd100, 18'd5);
    wait_done(d, 2000);
    chk("t4_queue_empty", exp_q.size(), 0);
    repeat (60) @(negedge CLOCK_50_I);
    chk("t4_single_done", done_cnt - d, 1);

    // 5: reset during the second byte
    mem[18'h20] = 16'h1234;
    push_word(16'h1234);
    d  = done_cnt;
    f0 = frames;
    start(18'h20, 18'd1);
    k = 0;
    while (!(frames == f0 + 1 && rx_act && rx_cnt >= 6) && k < 500) begin
      @(negedge CLOCK_50_I);
      k++;
    end
    chk("t5_reached_byte2", k < 500, 1);
    chk("t5_line_low_before_rst", UART_TX_O, 0);
    resetn = 1'b0;
    #1;
    chk("t5_tx_async", UART_TX_O, 1);
    chk("t5_busy_async", Busy, 0);
    exp_q.delete();
    repeat (3) @(negedge CLOCK_50_I);
    @(posedge CLOCK_50_I); #1 resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
    chk("t5_no_done", done_cnt - d, 0);
    mem[18'h21] = 16'h5AC3;
    push_word(16'h5AC3);
    d = done_cnt;
    start(18'h21, 18'd1);
    wait_done(d, 600);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: four words back to back
    mem[18'h40] = 16'h8001;
    mem[18'h41] = 16'h7FFE;
    mem[18'h42] = 16'h00FF;
    mem[18'h43] = 16'hC3A5;
    push_word(16'h8001);
    push_word(16'h7FFE);
    push_word(16'h00FF);
    push_word(16'hC3A5);
    d  = done_cnt;
    f0 = frames;
    start(18'h40, 18'd4);
    wait_done(d, 3000);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_frames", frames - f0, 8);
    chk("t6_we_n_high", we_bad, 0);

    repeat (5) @(negedge CLOCK_50_I);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
